// File: rtl/jtpopeye_rom_arb.sv
// rtl/jtpopeye_rom_arb.sv - round-robin SDRAM read arbiter with a one-word ROM cache per slot
module jtpopeye_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS*DW-1:0] slot_data,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [AW-1:0]       sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic [DW-1:0]       data_read,
    input  logic                data_rdy,
    output logic                refresh_en
);
    localparam int IW = $clog2(SLOTS);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t         state_q, state_d;
    logic [SLOTS-1:0] valid_q, hit, miss;
    logic [AW-1:0]  tag_q  [SLOTS];
    logic [DW-1:0]  data_q [SLOTS];
    logic [AW-1:0]  addr_a [SLOTS];
    logic [IW-1:0]  last_q, gnt_q, pick, cand;
    logic           any_miss, dl_q, dl_fall, grant_en, fill_en;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_a[i]             = slot_addr[i*AW +: AW];
            hit[i]                = valid_q[i] && (tag_q[i] == addr_a[i]);
            miss[i]               = slot_cs[i] && !hit[i];
            slot_ok[i]            = slot_cs[i] && hit[i];
            slot_data[i*DW +: DW] = data_q[i];
        end
    end

    assign any_miss = |miss;
    assign dl_fall  = dl_q && !downloading;

    // Scan from farthest to nearest so the first missing slot after last wins.
    always_comb begin
        pick = last_q;
        cand = '0;
        for (int k = SLOTS; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % SLOTS);
            if (miss[cand]) pick = cand;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        fill_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!downloading && any_miss) begin
                    state_d  = WAIT_ACK;
                    grant_en = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    state_d = IDLE;
                    fill_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (loop_rst) begin
            state_d  = IDLE;
            grant_en = 1'b0;
            fill_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            last_q     <= IW'(SLOTS-1);
            gnt_q      <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
            refresh_en <= 1'b0;
            dl_q       <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            dl_q       <= downloading;
            refresh_en <= (state_q == IDLE) && !any_miss && !downloading;
            if (loop_rst) begin
                sdram_req <= 1'b0;
                valid_q   <= '0;
            end else begin
                if (grant_en) begin
                    gnt_q      <= pick;
                    sdram_addr <= addr_a[pick];
                    sdram_req  <= 1'b1;
                end else if (state_q == WAIT_ACK && sdram_ack) begin
                    sdram_req <= 1'b0;
                end
                // Tag comes from the latched request, so a moved slot address keeps missing.
                if (fill_en) begin
                    data_q[gnt_q] <= data_read;
                    tag_q[gnt_q]  <= sdram_addr;
                    last_q        <= gnt_q;
                end
                if (dl_fall)      valid_q        <= '0;
                else if (fill_en) valid_q[gnt_q] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// tb/tb_jtpopeye_rom_arb.sv - directed and randomized checks of jtpopeye_rom_arb against a reference model
module tb_jtpopeye_rom_arb;
    localparam int S  = 4;
    localparam int AW = 22;
    localparam int DW = 32;
    typedef logic [127:0] v_t;

    logic            clk = 1'b0;
    logic            rst, downloading, loop_rst, sdram_ack, data_rdy, sdram_req, refresh_en;
    logic [S-1:0]    slot_cs, slot_ok;
    logic [S*AW-1:0] slot_addr;
    logic [S*DW-1:0] slot_data;
    logic [AW-1:0]   sdram_addr;
    logic [DW-1:0]   data_read;

    always #5 clk = ~clk;

    jtpopeye_rom_arb #(.SLOTS(S), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
        .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_data(slot_data), .slot_ok(slot_ok),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .data_read(data_read), .data_rdy(data_rdy), .refresh_en(refresh_en)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input v_t act, input v_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: cache contents plus at most one in-flight access.
    bit            m_init = 0;
    bit            m_valid [S];
    logic [AW-1:0] m_tag   [S];
    logic [DW-1:0] m_data  [S];
    int            m_last, m_pend, m_slot, m_nxt, m_s;
    logic [AW-1:0] m_saddr;
    bit            m_req, m_refresh, m_dl_prev, m_any;

    function automatic logic [AW-1:0] a_of(input int i);
        return slot_addr[i*AW +: AW];
    endfunction

    function automatic bit hits(input int i);
        return m_valid[i] && (m_tag[i] == a_of(i));
    endfunction

    function automatic bit wants(input int i);
        return slot_cs[i] && !hits(i);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            for (int i = 0; i < S; i++) begin
                m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0;
            end
            m_last = S-1; m_pend = 0; m_slot = 0; m_saddr = '0;
            m_req = 0; m_refresh = 0; m_dl_prev = 0;
        end else if (m_init) begin
            m_any = 0;
            m_nxt = -1;
            for (int k = 1; k <= S; k++) begin
                m_s = (m_last + k) % S;
                if (wants(m_s)) begin
                    m_any = 1;
                    if (m_nxt < 0) m_nxt = m_s;
                end
            end
            m_refresh = (m_pend == 0) && !m_any && !downloading;
            if (loop_rst) begin
                m_pend = 0;
                m_req  = 0;
                for (int i = 0; i < S; i++) m_valid[i] = 0;
            end else begin
                if (m_pend == 0 && m_any && !downloading) begin
                    m_pend = 1; m_slot = m_nxt; m_saddr = a_of(m_nxt); m_req = 1;
                end else if (m_pend == 1 && sdram_ack) begin
                    m_pend = 2; m_req = 0;
                end else if (m_pend == 2 && data_rdy) begin
                    m_data[m_slot] = data_read; m_tag[m_slot] = m_saddr;
                    m_valid[m_slot] = 1; m_last = m_slot; m_pend = 0;
                end
                if (m_dl_prev && !downloading)
                    for (int i = 0; i < S; i++) m_valid[i] = 0;
            end
            m_dl_prev = downloading;
        end
    end

    always @(negedge clk) begin
        logic [S-1:0]    eok;
        logic [S*DW-1:0] edata;
        if (m_init) begin
            for (int i = 0; i < S; i++) begin
                eok[i]             = slot_cs[i] && hits(i);
                edata[i*DW +: DW]  = m_data[i];
            end
            chk("sdram_req",  v_t'(sdram_req),  v_t'(m_req));
            chk("sdram_addr", v_t'(sdram_addr), v_t'(m_saddr));
            chk("refresh_en", v_t'(refresh_en), v_t'(m_refresh));
            chk("slot_ok",    v_t'(slot_ok),    v_t'(eok));
            chk("slot_data",  v_t'(slot_data),  v_t'(edata));
        end
    end

    logic [AW-1:0] gq[$];
    bit            req_prev = 0;
    always @(negedge clk) begin
        if (sdram_req === 1'b1 && !req_prev) gq.push_back(sdram_addr);
        req_prev = (sdram_req === 1'b1);
    end

    // SDRAM responder with programmable latencies and optional stray pulses.
    int ack_lat = 2, rdy_lat = 4, acnt, dcnt;
    bit noise = 0;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        if (a == 22'h123) return 32'hDEADBEEF;
        return {a[9:0], a} ^ 32'h5A5A_1234;
    endfunction

    initial begin
        sdram_ack = 0; data_rdy = 0; data_read = '0; acnt = 0; dcnt = 0;
        forever begin
            @(posedge clk); #1;
            sdram_ack = 0;
            data_rdy  = 0;
            if (m_pend == 1) begin
                acnt++;
                if (acnt >= ack_lat) begin sdram_ack = 1; acnt = 0; end
            end else acnt = 0;
            if (m_pend == 2) begin
                dcnt++;
                if (dcnt >= rdy_lat) begin data_rdy = 1; data_read = word_of(m_saddr); dcnt = 0; end
            end else dcnt = 0;
            if (noise) begin
                if (m_pend != 1 && $urandom_range(0, 5) == 0) sdram_ack = 1;
                if (m_pend != 2 && $urandom_range(0, 5) == 0) begin
                    data_rdy = 1; data_read = $urandom;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    task automatic wait_ok(input string name, input logic [S-1:0] mask, input int bound);
        int k = 0;
        while ((slot_ok & mask) != mask && k < bound) begin step(1); k++; end
        chk(name, v_t'((slot_ok & mask) == mask), v_t'(1));
    endtask

    task automatic wait_grants(input string name, input int n, input int bound);
        int k = 0;
        while (gq.size() < n && k < bound) begin step(1); k++; end
        chk(name, v_t'(gq.size() >= n), v_t'(1));
    endtask

    int            k, viol;
    bit            ok_seen;
    logic [AW-1:0] exp_q[$];

    initial begin
        rst = 1; downloading = 0; loop_rst = 0; slot_cs = '0; slot_addr = '0;
        step(3);
        chk("rst_req",     v_t'(sdram_req),  v_t'(0));
        chk("rst_addr",    v_t'(sdram_addr), v_t'(0));
        chk("rst_refresh", v_t'(refresh_en), v_t'(0));
        chk("rst_ok",      v_t'(slot_ok),    v_t'(0));
        chk("rst_data",    v_t'(slot_data),  v_t'(0));
        rst = 0;

        // single miss on slot 2
        set_addr(2, 22'h123); slot_cs = 4'b0100;
        chk("miss_req_same_cycle", v_t'(sdram_req), v_t'(0));
        step(1);
        chk("miss_req_next_cycle", v_t'(sdram_req),  v_t'(1));
        chk("miss_addr",           v_t'(sdram_addr), v_t'(22'h123));
        k = 1;
        while (!slot_ok[2] && k < 20) begin step(1); k++; end
        chk("miss_to_ok_cycles", v_t'(k), v_t'(7));
        chk("miss_data", v_t'(slot_data[2*DW +: DW]), v_t'(32'hDEADBEEF));
        slot_cs = '0; step(2);
        slot_cs = 4'b0100; #1;
        chk("rehit_zero_latency", v_t'(slot_ok[2]), v_t'(1));
        step(10);
        chk("rehit_no_req", v_t'(gq.size()), v_t'(1));

        // round robin
        rst = 1; step(2); rst = 0; gq.delete();
        for (int i = 0; i < S; i++) set_addr(i, AW'(22'h200 + i));
        slot_cs = 4'hF;
        wait_grants("rr_two", 2, 40);
        set_addr(1, 22'h301);
        wait_grants("rr_five", 5, 120);
        exp_q = '{22'h200, 22'h201, 22'h202, 22'h203, 22'h301};
        for (int i = 0; i < 5; i++)
            if (gq.size() > i) chk($sformatf("rr_order_%0d", i), v_t'(gq[i]), v_t'(exp_q[i]));
        wait_ok("rr_all_ok", 4'hF, 60);

        // address change while waiting for data
        rst = 1; step(2); rst = 0; gq.delete();
        set_addr(0, 22'h10); slot_cs = 4'b0001;
        wait_grants("ac_first", 1, 20);
        k = 0;
        while (sdram_req && k < 20) begin step(1); k++; end
        set_addr(0, 22'h11);
        ok_seen = 0; k = 0;
        while (gq.size() < 2 && k < 40) begin step(1); if (slot_ok[0]) ok_seen = 1; k++; end
        chk("ac_ok_stale",     v_t'(ok_seen),   v_t'(0));
        chk("ac_second_grant", v_t'(gq.size()), v_t'(2));
        if (gq.size() >= 2) chk("ac_second_addr", v_t'(gq[1]), v_t'(22'h11));
        wait_ok("ac_refetch_ok", 4'b0001, 40);

        // loop_rst during WAIT_ACK
        ack_lat = 6; gq.delete();
        set_addr(1, 22'h40); slot_cs = 4'b0011;
        wait_grants("lr_grant", 1, 20);
        chk("lr_slot0_hit_before", v_t'(slot_ok[0]), v_t'(1));
        loop_rst = 1; step(1); loop_rst = 0;
        chk("lr_req_dropped", v_t'(sdram_req), v_t'(0));
        chk("lr_ok_cleared",  v_t'(slot_ok),   v_t'(0));
        ack_lat = 2;
        wait_ok("lr_refetch", 4'b0011, 60);

        // download freeze and invalidation
        rst = 1; step(2); rst = 0; gq.delete();
        set_addr(0, 22'h500); set_addr(1, 22'h501); slot_cs = 4'b0011;
        wait_ok("dl_pre", 4'b0011, 60);
        set_addr(2, 22'h502); set_addr(3, 22'h503); slot_cs = 4'hF; downloading = 1;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (sdram_req !== 1'b0 || refresh_en !== 1'b0) viol++;
        end
        chk("dl_quiet",    v_t'(viol),      v_t'(0));
        chk("dl_no_grant", v_t'(gq.size()), v_t'(2));
        downloading = 0;
        wait_grants("dl_resume", 6, 120);
        exp_q = '{22'h502, 22'h503, 22'h500, 22'h501};
        for (int i = 0; i < 4; i++)
            if (gq.size() > i + 2) chk($sformatf("dl_order_%0d", i), v_t'(gq[i+2]), v_t'(exp_q[i]));
        wait_ok("dl_all_ok", 4'hF, 100);

        // refresh gating
        step(2);
        chk("rf_hit_refresh", v_t'(refresh_en), v_t'(1));
        set_addr(3, 22'h603);
        step(1);
        chk("rf_miss_drop", v_t'(refresh_en), v_t'(0));
        viol = 0; k = 0;
        while (!slot_ok[3] && k < 40) begin step(1); if (refresh_en) viol++; k++; end
        chk("rf_low_during", v_t'(viol),       v_t'(0));
        chk("rf_ok",         v_t'(slot_ok[3]), v_t'(1));
        chk("rf_low_at_ok",  v_t'(refresh_en), v_t'(0));
        step(1);
        chk("rf_back", v_t'(refresh_en), v_t'(1));

        // randomized traffic with stray SDRAM pulses
        noise = 1;
        for (int c = 0; c < 2500; c++) begin
            step(1);
            ack_lat = int'($urandom_range(1, 3));
            rdy_lat = int'($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) slot_cs = S'($urandom);
            if ($urandom_range(0, 3) == 0) set_addr(int'($urandom_range(0, S-1)), AW'($urandom_range(0, 5)));
            loop_rst = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 120) == 0) downloading = !downloading;
            rst = ($urandom_range(0, 700) == 0);
        end
        noise = 0; rst = 0; loop_rst = 0; downloading = 0;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtpopeye_rom_arb.md
# jtpopeye_rom_arb

Round-robin arbiter that shares the single game-side SDRAM read port among up to `SLOTS` ROM requesters: main CPU, sound, character and sprite ROMs. Each slot has a one-word cache, and a slot is served only when its address misses. The block sits between the game-side ROM clients and the frame's `sdram_addr`/`sdram_req`/`sdram_ack`/`data_read`/`data_rdy`/`refresh_en`/`loop_rst` port. It also keeps the port quiet during ROM download.

## Interface
Parameters:
- `SLOTS`, 4: number of requesters, 2..8.
- `AW`, 22: SDRAM word address width.
- `DW`, 32: SDRAM read data width.

Ports:
- `clk` in 1: system clock. Single clock domain; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `downloading` in 1: ROM download in progress. Arbitration is frozen.
- `loop_rst` in 1: frame SDRAM loop reset. Aborts the access and invalidates all caches.
- `slot_cs` in `SLOTS`: per-slot read enable.
- `slot_addr` in `SLOTS*AW`: packed per-slot word address. Slot i is `[i*AW +: AW]`.
- `slot_data` out `SLOTS*DW`: packed per-slot cached word, registered.
- `slot_ok` out `SLOTS`: `slot_data` is valid for the current `slot_addr`.
- `sdram_addr` out `AW`: address presented to SDRAM, registered.
- `sdram_req` out 1: request, registered. Level held until ack.
- `sdram_ack` in 1: one-cycle pulse. SDRAM has accepted the address.
- `data_read` in `DW`: SDRAM read data.
- `data_rdy` in 1: one-cycle pulse. `data_read` is valid.
- `refresh_en` out 1: SDRAM may refresh. Registered.

## Operation
Per-slot state:
- `valid[i]`, `tag[i]` (AW bits), `data[i]` (DW bits).
- `miss[i] = slot_cs[i] & ~(valid[i] & tag[i]==addr_i)`.
- `slot_ok[i] = slot_cs[i] & valid[i] & (tag[i]==addr_i)`. Combinational from registers and inputs.

State machine (IDLE, WAIT_ACK, WAIT_DATA):
- **IDLE**
  - Stays in IDLE if `downloading`, `loop_rst`, or no `miss` bit is set.
  - Otherwise grants the first slot with `miss` set, searching from `last+1` and wrapping modulo `SLOTS`. `last` resets to `SLOTS-1`, so slot 0 is searched first after reset.
  - On grant: latch `gnt`, and latch `req_addr = addr_gnt` into `sdram_addr`. Set `sdram_req=1` and go to WAIT_ACK.
- **WAIT_ACK**
  - Holds `sdram_req` and `sdram_addr` until `sdram_ack`.
  - On ack: clear `sdram_req` and go to WAIT_DATA.
- **WAIT_DATA**
  - On `data_rdy`: write `data[gnt] <= data_read`, `tag[gnt] <= req_addr`, `valid[gnt] <= 1`. Set `last <= gnt` and go to IDLE.

Rules:
- The stored tag is the latched request address, not the live one. If a slot's address changed mid-access, the word is stored but `slot_ok` stays low. A new miss is raised on the next arbitration.
- A `slot_cs` drop mid-access does not abort the access; the word is still stored.
- `slot_cs` low does not invalidate that slot's cache.
- `sdram_ack` outside WAIT_ACK is ignored. `data_rdy` outside WAIT_DATA is ignored.
- `refresh_en <= (state==IDLE) & ~|miss & ~downloading`.
- `loop_rst` takes priority over everything except `rst`. It forces IDLE, `sdram_req=0`, and clears all `valid`.
- `downloading` rising during WAIT_ACK or WAIT_DATA: the current access completes normally, then the FSM stays in IDLE. The falling edge of `downloading` clears all `valid` (ROM contents changed).

## Timing
Reset values, after `rst`:
- State IDLE, `sdram_req=0`, `sdram_addr=0`, `refresh_en=0`.
- All `valid=0`, `slot_data=0`, `slot_ok=0`, `last=SLOTS-1`.

Handshake:
- The miss is seen in cycle n. `sdram_req` rises at the edge ending cycle n, so it is visible in n+1.
- After `data_rdy` at cycle m, `slot_data`/`slot_ok` update at the edge ending m and are visible in m+1.
- Minimum miss-to-ok latency: 3 cycles plus SDRAM ack and data latency.
- Back-to-back: a new grant can occur in the first IDLE cycle after `data_rdy`. `sdram_req` is low for at least one cycle between accesses.

Arbitration and hits:
- Arbitration is fair. With all slots missing continuously, each slot is served at most once per `SLOTS` grants.
- A hit is zero-latency: `slot_ok` is high in the same cycle that `slot_addr` equals the tag.
- `sdram_addr` is stable for the whole time `sdram_req` is high.

## Test plan
- Single miss: reset, slot 2 `cs=1`, addr 0x00123, SDRAM model with ack 2 cycles after req and rdy 4 cycles after ack, data 0xDEADBEEF.
  - `sdram_req` high 1 cycle after `cs`; `sdram_addr`=0x00123.
  - Slot 2 `slot_ok`=1 and `slot_data`=0xDEADBEEF one cycle after rdy.
  - Re-reading 0x00123 issues no new req.
- Round-robin: all 4 slots miss at once. Grant order is 0,1,2,3. After slot 1 re-misses, the next grant is 2, not 1.
- Address change mid-access: slot 0 changes 0x10 to 0x11 during WAIT_DATA.
  - `slot_ok[0]` stays 0 after rdy.
  - A second request for 0x11 follows, then `slot_ok[0]`=1.
- `loop_rst` asserted during WAIT_ACK:
  - `sdram_req`=0 next cycle, FSM back in IDLE.
  - Every previously valid slot has `slot_ok`=0 until re-fetched.
- Download:
  - `downloading`=1 with misses pending: no req and `refresh_en`=0 for 100 cycles.
  - On the fall of `downloading`, caches are invalidated and requests resume in slot order.
- Refresh gating:
  - All slots hitting: `refresh_en`=1.
  - One new miss: `refresh_en`=0 the next cycle and stays 0 until its data returns and no miss remains.
